// File: rtl/i2c_csr_arbiter_if.sv
// Signal bundle between the two CSR requesters, the arbiter and the downstream CSR port.
// The arbiter connects through the slave modport; the requester/memory side uses master.
interface i2c_csr_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_ack;
    logic [DW-1:0] a_rdata;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_ack;
    logic [DW-1:0] b_rdata;

    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wr_data;
    logic [DW-1:0] m_rd_data;
    logic          m_en;
    logic          m_we;
    logic          m_re;

    logic          grant_id;
    logic          busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  m_rd_data,
        output a_ack, a_rdata, b_ack, b_rdata,
        output m_addr, m_wr_data, m_en, m_we, m_re,
        output grant_id, busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output m_rd_data,
        input  a_ack, a_rdata, b_ack, b_rdata,
        input  m_addr, m_wr_data, m_en, m_we, m_re,
        input  grant_id, busy
    );
endinterface

// File: rtl/i2c_csr_arbiter.sv
// Two-port arbiter in front of the I2C master's single CSR port: serialises A (AXI-lite bridge)
// and B (command sequencer) accesses, issues one-cycle strobes and returns ack + read data.
module i2c_csr_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned RD_LAT   = 1,  // legal 1..4
    parameter int unsigned ARB_MODE = 0   // 0 round-robin, 1 fixed priority to A
) (
    input  logic               s_axi_aclk,
    input  logic               s_axi_aresetn,
    i2c_csr_arbiter_if.slave   io_csr
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

    state_e        r_state, w_state_d;
    logic [2:0]    r_cnt, w_cnt_d;
    logic          r_rr_last;
    logic          r_grant, w_grant_d;
    logic          r_we;
    logic [AW-1:0] r_m_addr;
    logic [DW-1:0] r_m_wr_data;
    logic          r_m_en, r_m_we, r_m_re;
    logic          r_a_ack, r_b_ack;
    logic [DW-1:0] r_a_rdata, r_b_rdata;
    logic          r_busy;

    logic          w_latch;
    logic          w_win;
    logic          w_capture;
    logic          w_we_sel;
    logic [AW-1:0] w_addr_sel;
    logic [DW-1:0] w_wdata_sel;
    logic          w_we_d;
    logic          w_issue;
    logic          w_ack;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_grant_d = r_grant;
        w_latch   = 1'b0;
        w_win     = 1'b0;
        w_capture = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (io_csr.a_req || io_csr.b_req) begin
                    w_latch   = 1'b1;
                    w_state_d = StIssue;
                    // On a tie, round-robin hands the grant to whoever did not win last time.
                    if (io_csr.a_req && io_csr.b_req) begin
                        w_win = (ARB_MODE == 1) ? 1'b0 : ~r_rr_last;
                    end else begin
                        w_win = io_csr.b_req;
                    end
                    w_grant_d = w_win;
                end
            end
            StIssue: begin
                if (r_we) begin
                    w_state_d = StAck;
                end else begin
                    w_state_d = StWait;
                    w_cnt_d   = 3'(RD_LAT);
                end
            end
            StWait: begin
                w_cnt_d = r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    w_capture = 1'b1;
                    w_state_d = StAck;
                end
            end
            StAck: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        w_we_sel    = w_win ? io_csr.b_we    : io_csr.a_we;
        w_addr_sel  = w_win ? io_csr.b_addr  : io_csr.a_addr;
        w_wdata_sel = w_win ? io_csr.b_wdata : io_csr.a_wdata;
        w_we_d      = w_latch ? w_we_sel : r_we;
        w_issue     = (w_state_d == StIssue);
        w_ack       = (w_state_d == StAck);
    end

    // Outputs are computed from the next state so every port is driven straight from a flop.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state     <= StIdle;
            r_cnt       <= 3'd0;
            r_rr_last   <= 1'b1;
            r_grant     <= 1'b0;
            r_we        <= 1'b0;
            r_m_addr    <= '0;
            r_m_wr_data <= '0;
            r_m_en      <= 1'b0;
            r_m_we      <= 1'b0;
            r_m_re      <= 1'b0;
            r_a_ack     <= 1'b0;
            r_b_ack     <= 1'b0;
            r_a_rdata   <= '0;
            r_b_rdata   <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_grant <= w_grant_d;
            if (w_latch) begin
                r_rr_last   <= w_win;
                r_we        <= w_we_sel;
                r_m_addr    <= w_addr_sel;
                r_m_wr_data <= w_wdata_sel;
            end
            r_m_en  <= w_issue;
            r_m_we  <= w_issue & w_we_d;
            r_m_re  <= w_issue & ~w_we_d;
            r_a_ack <= w_ack & ~w_grant_d;
            r_b_ack <= w_ack & w_grant_d;
            r_busy  <= (w_state_d != StIdle);
            if (w_capture && !r_grant) r_a_rdata <= io_csr.m_rd_data;
            if (w_capture && r_grant)  r_b_rdata <= io_csr.m_rd_data;
        end
    end

    assign io_csr.m_addr    = r_m_addr;
    assign io_csr.m_wr_data = r_m_wr_data;
    assign io_csr.m_en      = r_m_en;
    assign io_csr.m_we      = r_m_we;
    assign io_csr.m_re      = r_m_re;
    assign io_csr.a_ack     = r_a_ack;
    assign io_csr.a_rdata   = r_a_rdata;
    assign io_csr.b_ack     = r_b_ack;
    assign io_csr.b_rdata   = r_b_rdata;
    assign io_csr.grant_id  = r_grant;
    assign io_csr.busy      = r_busy;

    a_no_we_re: assert property (@(posedge s_axi_aclk) disable iff (!s_axi_aresetn)
        !(r_m_we && r_m_re));
    a_one_ack: assert property (@(posedge s_axi_aclk) disable iff (!s_axi_aresetn)
        !(r_a_ack && r_b_ack));

endmodule
